// File: rtl/lsu_dmem_stage.sv
// lsu_dmem_stage
//   MEM-stage load/store unit with a private, word-organised data RAM.
//   One request is in flight at a time. Loads read the RAM on the accept
//   edge and lane-select/extend in the following READ cycle. Stores write
//   byte lanes on the accept edge. The response is held in registers until
//   writeback takes it.
//
//   Handshakes: a transfer happens on a rising clk_i edge where both valid
//   and ready are high. A valid source holds its payload stable until that
//   edge. Ready never depends combinationally on valid.
//
// Ports
//   clk_i, rst_i         clock and asynchronous active-high reset
//   flush_i              drops an in-flight load response
//   req_*                request channel (valid/ready, we, size, unsigned,
//                        addr, wdata, tag)
//   resp_*               response channel (valid/ready, data, tag, we, err)
//   dbg_state_o          current FSM state, for observation only
module lsu_dmem_stage #(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 2048,
   parameter int TAG_W     = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [1:0]       req_size_i,
   input  logic             req_unsigned_i,
   input  logic [XLEN-1:0]  req_addr_i,
   input  logic [XLEN-1:0]  req_wdata_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [XLEN-1:0]  resp_data_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic             resp_we_o,
   output logic             resp_err_o,
   output logic [1:0]       dbg_state_o
);

   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(MEM_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       r_state;
   logic [XLEN-1:0]  r_mem [MEM_WORDS];
   logic [XLEN-1:0]  r_rdata;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [OFF_W-1:0] r_off;
   logic [TAG_W-1:0] r_tag;
   logic [XLEN-1:0]  r_resp_data;
   logic [TAG_W-1:0] r_resp_tag;
   logic             r_resp_we;
   logic             r_resp_err;

   logic             w_accept;
   logic [2:0]       w_align;
   logic             w_fault;
   logic [OFF_W-1:0] w_off;
   logic [IDX_W-1:0] w_idx;
   logic [BYTES-1:0] w_len;
   logic [BYTES-1:0] w_be;
   logic [XLEN-1:0]  w_wdata_sh;
   logic [XLEN-1:0]  w_shifted;
   logic [XLEN-1:0]  w_mask;
   logic             w_sign;
   logic [XLEN-1:0]  w_ext;

   assign req_ready_o  = (r_state == S_IDLE);
   assign w_accept     = req_valid_i && req_ready_o;
   assign w_off        = req_addr_i[OFF_W-1:0];
   assign w_idx        = req_addr_i[OFF_W +: IDX_W];

   // Low address bits that must be zero for a naturally aligned access.
   assign w_align = (3'd1 << req_size_i) - 3'd1;

   // Any address bit above the RAM's word index puts the access out of range;
   // a dword access does not exist on a 32-bit datapath.
   assign w_fault = (|(req_addr_i[2:0] & w_align))
                 || (|(req_addr_i >> (OFF_W + IDX_W)))
                 || ((req_size_i == 2'd3) && (XLEN == 32));

   always_comb begin
      w_len = '1;
      case (req_size_i)
         2'd0:    w_len = BYTES'(1);
         2'd1:    w_len = BYTES'(3);
         2'd2:    w_len = BYTES'(15);
         default: w_len = '1;
      endcase
   end

   assign w_be       = w_len << w_off;
   assign w_wdata_sh = req_wdata_i << {w_off, 3'b000};

   // Load extension works on the word captured at accept time, shifted so the
   // addressed byte lands at bit 0; the mask keeps only the accessed width.
   assign w_shifted = r_rdata >> {r_off, 3'b000};

   always_comb begin
      w_mask = '1;
      w_sign = 1'b0;
      case (r_size)
         2'd0: begin
            w_mask = XLEN'(8'hFF);
            w_sign = w_shifted[7];
         end
         2'd1: begin
            w_mask = XLEN'(16'hFFFF);
            w_sign = w_shifted[15];
         end
         2'd2: begin
            w_mask = XLEN'(32'hFFFF_FFFF);
            w_sign = w_shifted[31];
         end
         default: begin
            w_mask = '1;
            w_sign = 1'b0;
         end
      endcase
   end

   assign w_ext = (w_shifted & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);

   // RAM: not reset. Write and read are mutually exclusive by construction.
   always_ff @(posedge clk_i) begin
      if (w_accept && !w_fault) begin
         if (req_we_i) begin
            for (int b = 0; b < BYTES; b++) begin
               if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
            end
         end else begin
            r_rdata <= r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_size      <= 2'd0;
         r_unsigned  <= 1'b0;
         r_off       <= '0;
         r_tag       <= '0;
         r_resp_data <= '0;
         r_resp_tag  <= '0;
         r_resp_we   <= 1'b0;
         r_resp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_fault || req_we_i) begin
                     r_state     <= S_RESP;
                     r_resp_data <= '0;
                     r_resp_tag  <= req_tag_i;
                     r_resp_we   <= req_we_i;
                     r_resp_err  <= w_fault;
                  end else begin
                     r_state    <= S_READ;
                     r_size     <= req_size_i;
                     r_unsigned <= req_unsigned_i;
                     r_off      <= w_off;
                     r_tag      <= req_tag_i;
                  end
               end
            end
            S_READ: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state     <= S_RESP;
                  r_resp_data <= w_ext;
                  r_resp_tag  <= r_tag;
                  r_resp_we   <= 1'b0;
                  r_resp_err  <= 1'b0;
               end
            end
            S_RESP: begin
               // A flush only kills load responses; store results already hit RAM.
               if (resp_ready_i || (flush_i && !r_resp_we)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign resp_valid_o = (r_state == S_RESP);
   assign resp_data_o  = r_resp_data;
   assign resp_tag_o   = r_resp_tag;
   assign resp_we_o    = r_resp_we;
   assign resp_err_o   = r_resp_err;
   assign dbg_state_o  = r_state;

endmodule
